// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm datapath.
// Contents:
//   fill_state_e - fill-bank state (FILLING, FULL_WAIT)
//   BN_WIDTH     - default data word width, shared with the batch-norm stage
//   BN_CHANNELS  - default channels per frame, shared with the batch-norm stage
//   bn_ch_w()    - width of a channel tag for a given channel count
package bn_pkg;

    typedef enum logic {
        FILLING   = 1'b0,
        FULL_WAIT = 1'b1
    } fill_state_e;

    localparam int unsigned BN_WIDTH    = 16;
    localparam int unsigned BN_CHANNELS = 16;

    function automatic int unsigned bn_ch_w(input int unsigned channels);
        return (channels < 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/bn_frame_bank.sv
// One frame bank: CHANNELS words of storage, a single write port and a packed read-out.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears storage to zero)
//   i_we      - write enable
//   i_waddr   - slot to write
//   i_wdata   - word to store
//   o_packed  - all slots packed, slot k at [k*WIDTH +: WIDTH]
module bn_frame_bank
    import bn_pkg::*;
#(
    parameter int unsigned WIDTH    = BN_WIDTH,
    parameter int unsigned CHANNELS = BN_CHANNELS,
    parameter int unsigned CH_W     = bn_ch_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_we,
    input  logic [CH_W-1:0]           i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    output logic [CHANNELS*WIDTH-1:0] o_packed
);

    logic [WIDTH-1:0] r_mem [CHANNELS];

    // Zeroing on reset makes the output bank read 0 until the first frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_pack
        assign o_packed[k*WIDTH +: WIDTH] = r_mem[k];
    end

endmodule

// File: rtl/bn_frame_collector.sv
// Collects the channel-tagged scalar stream from the batch-norm stage into packed frames
// and hands them downstream over valid/ready. Two banks: one fills while the other is
// presented; r_sel names the fill bank and flips on every swap.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   y_in          - data word
//   channel_in    - channel tag of y_in
//   valid_in      - qualifier for y_in/channel_in (no backpressure)
//   clear         - flush the partially filled (or held) fill bank
//   frame_packed  - output frame, channel k at [k*WIDTH +: WIDTH]
//   frame_valid   - output frame available
//   frame_ready   - downstream accepts the frame
//   fill_count    - distinct channels captured in the fill bank
//   overflow      - sticky, word dropped while both banks were full
//   dup_error     - sticky, channel written twice within one frame
module bn_frame_collector
    import bn_pkg::*;
#(
    parameter  int unsigned WIDTH    = BN_WIDTH,
    parameter  int unsigned CHANNELS = BN_CHANNELS,
    localparam int unsigned CH_W     = bn_ch_w(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          y_in,
    input  logic [CH_W-1:0]           channel_in,
    input  logic                      valid_in,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] frame_packed,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [CH_W:0]             fill_count,
    output logic                      overflow,
    output logic                      dup_error
);

    fill_state_e         r_state, w_state_d;
    logic [CHANNELS-1:0] r_mask, w_mask_d;
    logic [CH_W:0]       r_count, w_count_d;
    logic                r_sel, w_sel_d;
    logic                r_valid, w_valid_d;
    logic                r_overflow, w_overflow_d;
    logic                r_dup, w_dup_d;

    logic                      w_in_range, w_wr, w_drain, w_is_dup, w_complete;
    logic [CHANNELS-1:0]       w_onehot, w_mask_set;
    logic [CHANNELS*WIDTH-1:0] w_packed0, w_packed1;

    assign w_in_range = ({1'b0, channel_in} < (CH_W+1)'(CHANNELS));
    assign w_onehot   = {{(CHANNELS-1){1'b0}}, 1'b1} << channel_in;
    assign w_mask_set = r_mask | w_onehot;
    assign w_drain    = r_valid & frame_ready;
    // clear wins over a same-cycle write; nothing is stored while a full bank is held.
    assign w_wr       = valid_in & w_in_range & !clear & (r_state == FILLING);
    assign w_is_dup   = |(r_mask & w_onehot);
    assign w_complete = w_wr & (&w_mask_set);

    always_comb begin
        w_state_d    = r_state;
        w_mask_d     = r_mask;
        w_count_d    = r_count;
        w_sel_d      = r_sel;
        w_valid_d    = r_valid & !w_drain;
        w_overflow_d = r_overflow;
        w_dup_d      = r_dup;
        unique case (r_state)
            FILLING: begin
                if (clear) begin
                    w_mask_d  = '0;
                    w_count_d = '0;
                end else if (w_wr) begin
                    w_mask_d = w_mask_set;
                    if (w_is_dup) begin
                        w_dup_d = 1'b1;
                    end else begin
                        w_count_d = r_count + 1'b1;
                    end
                    if (w_complete) begin
                        if (!r_valid || w_drain) begin
                            w_sel_d   = !r_sel;
                            w_valid_d = 1'b1;
                            w_mask_d  = '0;
                            w_count_d = '0;
                        end else begin
                            w_state_d = FULL_WAIT;
                        end
                    end
                end
            end
            FULL_WAIT: begin
                if (clear) begin
                    w_state_d = FILLING;
                    w_mask_d  = '0;
                    w_count_d = '0;
                end else begin
                    if (valid_in) begin
                        w_overflow_d = 1'b1;
                    end
                    if (w_drain) begin
                        w_sel_d   = !r_sel;
                        w_valid_d = 1'b1;
                        w_mask_d  = '0;
                        w_count_d = '0;
                        w_state_d = FILLING;
                    end
                end
            end
            default: w_state_d = FILLING;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FILLING;
            r_mask     <= '0;
            r_count    <= '0;
            r_sel      <= 1'b0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_dup      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_mask     <= w_mask_d;
            r_count    <= w_count_d;
            r_sel      <= w_sel_d;
            r_valid    <= w_valid_d;
            r_overflow <= w_overflow_d;
            r_dup      <= w_dup_d;
        end
    end

    bn_frame_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wr & !r_sel),
        .i_waddr  (channel_in),
        .i_wdata  (y_in),
        .o_packed (w_packed0)
    );

    bn_frame_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wr & r_sel),
        .i_waddr  (channel_in),
        .i_wdata  (y_in),
        .o_packed (w_packed1)
    );

    // The output bank is whichever bank is not being filled.
    assign frame_packed = r_sel ? w_packed0 : w_packed1;
    assign frame_valid  = r_valid;
    assign fill_count   = r_count;
    assign overflow     = r_overflow;
    assign dup_error    = r_dup;

endmodule
